// File: rtl/mem_ctrl_arb.sv
// Byte-serial RAM/IO controller: arbitrates instruction-fetch lines and
// 1/2/4-byte load/stores onto a single 8-bit memory bus.
module mem_ctrl_arb #(
   parameter int         ADDR_W      = 32,
   parameter int         FETCH_BYTES = 4,
   parameter logic [1:0] IO_SEL      = 2'b11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic [7:0]               mem_din,
   output logic [7:0]               mem_dout,
   output logic [ADDR_W-1:0]        mem_a,
   output logic                     mem_wr,
   input  logic                     io_buffer_full,
   input  logic                     if_req,
   input  logic [ADDR_W-1:0]        if_addr,
   output logic                     if_done,
   output logic [8*FETCH_BYTES-1:0] if_data,
   input  logic                     ls_req,
   input  logic                     ls_we,
   input  logic [1:0]               ls_size,
   input  logic                     ls_signed,
   input  logic [ADDR_W-1:0]        ls_addr,
   input  logic [31:0]              ls_wdata,
   output logic                     ls_done,
   output logic [31:0]              ls_rdata
);

   localparam int CW = $clog2(FETCH_BYTES) + 1;
   localparam int DW = 8 * FETCH_BYTES;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q, len_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              ch_ls_q;
   logic              last_ls_q;
   logic [1:0]        size_q;
   logic              sgn_q;
   logic [DW-1:0]     buf_q, buf_d;
   logic [7:0]        mem_dout_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic              mem_wr_q, if_done_q, ls_done_q;
   logic [DW-1:0]     if_data_q;
   logic [31:0]       ls_rdata_q;

   logic              ls_ok, grant_ls, grant_if;
   logic [CW-1:0]     ls_len;
   logic [31:0]       ld_ext;

   // An IO store with the IO buffer full is invisible to arbitration.
   assign ls_ok    = ls_req && !(ls_we && ls_addr[17:16] == IO_SEL && io_buffer_full);
   assign grant_ls = ls_ok && (!if_req || !last_ls_q);
   assign grant_if = if_req && !grant_ls;

   always_comb begin
      case (ls_size)
         2'b00:   ls_len = CW'(1);
         2'b01:   ls_len = CW'(2);
         default: ls_len = CW'(4);
      endcase
   end

   // Buffer including the byte arriving on this edge, so the final byte
   // lands in the result in the same cycle done is raised.
   always_comb begin
      buf_d = buf_q;
      for (int i = 0; i < FETCH_BYTES; i++)
         if (CW'(i) == cnt_q - CW'(1)) buf_d[i*8 +: 8] = mem_din;
   end

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
         2'b01:   ld_ext = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
         default: ld_ext = buf_d[31:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ch_ls_q    <= 1'b0;
         last_ls_q  <= 1'b0;
         size_q     <= '0;
         sgn_q      <= 1'b0;
         buf_q      <= '0;
         mem_dout_q <= '0;
         mem_a_q    <= '0;
         mem_wr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else if (rdy) begin
         case (state_q)
            IDLE: begin
               if (!flush && (grant_ls || grant_if)) begin
                  last_ls_q <= grant_ls;
                  ch_ls_q   <= grant_ls;
                  addr_q    <= grant_ls ? ls_addr : if_addr;
                  mem_a_q   <= grant_ls ? ls_addr : if_addr;
                  len_q     <= grant_ls ? ls_len : CW'(FETCH_BYTES);
                  size_q    <= ls_size;
                  sgn_q     <= ls_signed;
                  cnt_q     <= CW'(1);
                  buf_q     <= '0;
                  if (grant_ls && ls_we) begin
                     mem_dout_q <= ls_wdata[7:0];
                     wdata_q    <= {8'h00, ls_wdata[31:8]};
                     mem_wr_q   <= 1'b1;
                     state_q    <= WRITE;
                  end else begin
                     mem_wr_q <= 1'b0;
                     state_q  <= READ;
                  end
               end
            end
            READ: begin
               if (flush) begin
                  mem_wr_q <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  buf_q <= buf_d;
                  if (cnt_q < len_q) begin
                     mem_a_q <= addr_q + ADDR_W'(cnt_q);
                     cnt_q   <= cnt_q + CW'(1);
                  end else begin
                     state_q <= DONE;
                     if (ch_ls_q) begin
                        ls_done_q  <= 1'b1;
                        ls_rdata_q <= ld_ext;
                     end else begin
                        if_done_q <= 1'b1;
                        if_data_q <= buf_d;
                     end
                  end
               end
            end
            WRITE: begin
               // Stores are committed once granted; flush is ignored here.
               if (cnt_q < len_q) begin
                  mem_a_q    <= addr_q + ADDR_W'(cnt_q);
                  mem_dout_q <= wdata_q[7:0];
                  wdata_q    <= wdata_q >> 8;
                  cnt_q      <= cnt_q + CW'(1);
               end else begin
                  mem_wr_q  <= 1'b0;
                  ls_done_q <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if_done_q <= 1'b0;
               ls_done_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_dout = mem_dout_q;
   assign mem_a    = mem_a_q;
   assign mem_wr   = mem_wr_q;
   assign if_done  = if_done_q;
   assign if_data  = if_data_q;
   assign ls_done  = ls_done_q;
   assign ls_rdata = ls_rdata_q;

endmodule
